// File: rtl/btzk_i2c_regseq.sv
// Register-access sequencer in front of the byte-level btzk_i2c master: one host
// request becomes a pointer byte plus a data byte (write) or a repeated-START read.
// Optional watchdog/abort path compiled in with BTZK_I2CSEQ_TIMEOUT_EN.
module btzk_i2c_regseq #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd1000000
) (
  input  logic       btzk_i2cseq_clk,
  input  logic       btzk_i2cseq_reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [6:0] req_dev_addr,
  input  logic [7:0] req_reg_addr,
  input  logic [7:0] req_wdata,
  output logic       resp_valid,
  output logic [7:0] resp_rdata,
  output logic       resp_err,
  output logic       resp_timeout,
  output logic       m_ena,
  output logic [6:0] m_addr,
  output logic       m_rw,
  output logic [7:0] m_data_wr,
  input  logic [7:0] m_data_rd,
  input  logic       m_busy,
  input  logic       m_ack_err
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PTR    = 3'd1,
    ST_SECOND = 3'd2,
    ST_LAST   = 3'd3,
    ST_DONE   = 3'd4
`ifdef BTZK_I2CSEQ_TIMEOUT_EN
    ,
    ST_ABORT  = 3'd5
`endif
  } state_t;

  state_t     state_r;
  logic       busy_q_r;
  logic       busy_rise_s;
  logic       accept_s;
  logic       timeout_s;
  logic       write_r;
  logic [7:0] wdata_r;
  logic       err_acc_r;
  logic       req_ready_r;
  logic       resp_valid_r;
  logic [7:0] resp_rdata_r;
  logic       resp_err_r;
  logic       resp_timeout_r;
  logic       m_ena_r;
  logic [6:0] m_addr_r;
  logic       m_rw_r;
  logic [7:0] m_data_wr_r;

  // A rising busy means the master has latched the command currently presented.
  assign busy_rise_s = m_busy & ~busy_q_r;
  assign accept_s    = (state_r == ST_IDLE) & req_valid & req_ready_r;

`ifdef BTZK_I2CSEQ_TIMEOUT_EN
  logic [31:0] wdog_r;

  assign timeout_s = (wdog_r == (TIMEOUT_CYCLES - 32'd1));

  // Watchdog: restarts on acceptance, counts only while a transaction is active.
  always_ff @(posedge btzk_i2cseq_clk or negedge btzk_i2cseq_reset_n) begin
    if (!btzk_i2cseq_reset_n) begin
      wdog_r <= 32'd0;
    end else if (accept_s) begin
      wdog_r <= 32'd0;
    end else if (((state_r == ST_PTR) || (state_r == ST_SECOND) || (state_r == ST_LAST)) && !timeout_s) begin
      wdog_r <= wdog_r + 32'd1;
    end else begin
      wdog_r <= wdog_r;
    end
  end
`else
  logic unused_timeout_s;

  assign timeout_s        = 1'b0;
  assign unused_timeout_s = ^TIMEOUT_CYCLES;
`endif

  // Sequencer FSM; all master-side and host-side outputs are registered here.
  always_ff @(posedge btzk_i2cseq_clk or negedge btzk_i2cseq_reset_n) begin
    if (!btzk_i2cseq_reset_n) begin
      state_r        <= ST_IDLE;
      busy_q_r       <= 1'b0;
      write_r        <= 1'b0;
      wdata_r        <= 8'h00;
      err_acc_r      <= 1'b0;
      req_ready_r    <= 1'b0;
      resp_valid_r   <= 1'b0;
      resp_rdata_r   <= 8'h00;
      resp_err_r     <= 1'b0;
      resp_timeout_r <= 1'b0;
      m_ena_r        <= 1'b0;
      m_addr_r       <= 7'h00;
      m_rw_r         <= 1'b0;
      m_data_wr_r    <= 8'h00;
    end else begin
      busy_q_r     <= m_busy;
      resp_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // A lingering busy from the previous STOP blocks acceptance.
          req_ready_r <= ~m_busy;
          m_ena_r     <= 1'b0;
          m_rw_r      <= 1'b0;
          m_data_wr_r <= 8'h00;
          if (accept_s) begin
            state_r     <= ST_PTR;
            req_ready_r <= 1'b0;
            write_r     <= req_write;
            wdata_r     <= req_wdata;
            err_acc_r   <= 1'b0;
            m_addr_r    <= req_dev_addr;
            m_ena_r     <= 1'b1;
            m_rw_r      <= 1'b0;
            m_data_wr_r <= req_reg_addr;
          end
        end
        ST_PTR, ST_SECOND, ST_LAST: begin
          if (timeout_s) begin
`ifdef BTZK_I2CSEQ_TIMEOUT_EN
            state_r        <= ST_ABORT;
            m_ena_r        <= 1'b0;
            m_rw_r         <= 1'b0;
            m_data_wr_r    <= 8'h00;
            resp_valid_r   <= 1'b1;
            resp_err_r     <= 1'b1;
            resp_timeout_r <= 1'b1;
            resp_rdata_r   <= 8'h00;
`endif
          end else if (state_r == ST_PTR) begin
            // Pointer latched: present the second byte; a read flips rw for a repeated START.
            if (busy_rise_s) begin
              state_r     <= ST_SECOND;
              m_rw_r      <= ~write_r;
              m_data_wr_r <= write_r ? wdata_r : 8'h00;
            end
          end else if (state_r == ST_SECOND) begin
            if (busy_rise_s) begin
              state_r     <= ST_LAST;
              m_ena_r     <= 1'b0;
              m_rw_r      <= 1'b0;
              m_data_wr_r <= 8'h00;
            end
          end else begin
            if (m_busy) begin
              err_acc_r <= err_acc_r | m_ack_err;
            end else begin
              state_r        <= ST_DONE;
              resp_valid_r   <= 1'b1;
              resp_err_r     <= err_acc_r | m_ack_err;
              resp_timeout_r <= 1'b0;
              resp_rdata_r   <= write_r ? 8'h00 : m_data_rd;
            end
          end
        end
        ST_DONE: begin
          state_r     <= ST_IDLE;
          req_ready_r <= ~m_busy;
        end
`ifdef BTZK_I2CSEQ_TIMEOUT_EN
        ST_ABORT: begin
          // The master may still be busy; IDLE holds off the next request until it clears.
          state_r     <= ST_IDLE;
          req_ready_r <= ~m_busy;
        end
`endif
        default: begin
          state_r     <= ST_IDLE;
          req_ready_r <= 1'b0;
          m_ena_r     <= 1'b0;
          m_rw_r      <= 1'b0;
          m_data_wr_r <= 8'h00;
        end
      endcase
    end
  end

  assign req_ready    = req_ready_r;
  assign resp_valid   = resp_valid_r;
  assign resp_rdata   = resp_rdata_r;
  assign resp_err     = resp_err_r;
  assign resp_timeout = resp_timeout_r;
  assign m_ena        = m_ena_r;
  assign m_addr       = m_addr_r;
  assign m_rw         = m_rw_r;
  assign m_data_wr    = m_data_wr_r;

endmodule

// File: tb/tb_btzk_i2c_regseq.sv
// Directed bench for btzk_i2c_regseq with a cycle-level model of the byte master.
// Watchdog scenario runs only when BTZK_I2CSEQ_TIMEOUT_EN is defined.
module tb_btzk_i2c_regseq;

  localparam int BYTE_CYC = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [6:0] req_dev_addr = 7'h00;
  logic [7:0] req_reg_addr = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic       resp_valid;
  logic [7:0] resp_rdata;
  logic       resp_err;
  logic       resp_timeout;
  logic       m_ena;
  logic [6:0] m_addr;
  logic       m_rw;
  logic [7:0] m_data_wr;
  logic [7:0] m_data_rd = 8'h00;
  logic       m_busy = 1'b0;
  logic       m_ack_err = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // master model controls and observations
  int          linger = 3;
  bit          nack_addr = 1'b0;
  bit          stuck = 1'b0;
  logic [7:0]  slave_rd = 8'h00;
  logic [15:0] log_q[$];
  logic        ena_after_rise = 1'b1;
  int          ready_viol = 0;
  logic        prev_busy = 1'b0;

  always #5 clk = ~clk;

  btzk_i2c_regseq #(.TIMEOUT_CYCLES(100)) dut (
    .btzk_i2cseq_clk     (clk),
    .btzk_i2cseq_reset_n (rst_n),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_write           (req_write),
    .req_dev_addr        (req_dev_addr),
    .req_reg_addr        (req_reg_addr),
    .req_wdata           (req_wdata),
    .resp_valid          (resp_valid),
    .resp_rdata          (resp_rdata),
    .resp_err            (resp_err),
    .resp_timeout        (resp_timeout),
    .m_ena               (m_ena),
    .m_addr              (m_addr),
    .m_rw                (m_rw),
    .m_data_wr           (m_data_wr),
    .m_data_rd           (m_data_rd),
    .m_busy              (m_busy),
    .m_ack_err           (m_ack_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Byte master model: ena latches a command 2 cycles later with a busy rise; each byte
  // lasts BYTE_CYC cycles; a second command is latched after a 1-cycle busy dip.
  initial begin : master_model
    bit rw2;
    forever begin
      cyc();
      if (m_ena) begin
        repeat (2) cyc();
        log_q.push_back({m_addr, m_rw, m_data_wr});
        m_busy    = 1'b1;
        m_ack_err = nack_addr;
        repeat (BYTE_CYC) cyc();
        while (stuck) cyc();
        if (m_ena) begin
          m_busy = 1'b0;
          cyc();
          rw2 = m_rw;
          log_q.push_back({m_addr, m_rw, m_data_wr});
          m_busy = 1'b1;
          cyc();
          ena_after_rise = m_ena;
          repeat (BYTE_CYC - 1) cyc();
          if (rw2) m_data_rd = slave_rd;
        end
        repeat (linger) cyc();
        m_busy = 1'b0;
      end
    end
  end

  // req_ready must never be offered when busy was high at the preceding edge.
  initial begin : ready_monitor
    forever begin
      @(posedge clk);
      #2;
      if (req_ready && prev_busy) ready_viol++;
      prev_busy = m_busy;
    end
  end

  initial begin : global_guard
    #2000000;
    $display("FAIL global_timeout: observed hang expected completion");
    $fatal(1, "bench time limit");
  end

  task automatic do_req(input bit wr, input logic [6:0] dev, input logic [7:0] ra,
                        input logic [7:0] wd, input bit hold, output int lat);
    int n;
    req_write    = wr;
    req_dev_addr = dev;
    req_reg_addr = ra;
    req_wdata    = wd;
    req_valid    = 1'b1;
    n = 0;
    while (!req_ready && n < 400) begin
      cyc();
      n++;
    end
    chk("accept_bound", {31'd0, n < 400}, 32'd1);
    cyc();
    if (!hold) req_valid = 1'b0;
    chk("ena_on_accept", {16'd0, m_ena, m_rw, m_addr, m_data_wr}, {16'd0, 1'b1, 1'b0, dev, ra});
    lat = 0;
    while (!resp_valid && lat < 400) begin
      cyc();
      lat++;
    end
    chk("resp_bound", {31'd0, lat < 400}, 32'd1);
  endtask

  initial begin : stimulus
    int lat;
    int cnt;
    int n;

    // reset state
    #7;
    chk("reset_outputs", {11'd0, req_ready, resp_valid, resp_rdata, resp_err, resp_timeout,
                          m_ena, m_rw, m_data_wr}, 32'd0);
    chk("reset_addr", {25'd0, m_addr}, 32'd0);
    #5 rst_n = 1'b1;
    cyc();
    chk("ready_after_reset", {31'd0, req_ready}, 32'd1);

    // write 0x50/0x1A <= 0xC3
    log_q.delete();
    do_req(1'b1, 7'h50, 8'h1A, 8'hC3, 1'b0, lat);
    chk("wr_latency", lat, 32'd23);
    chk("wr_bytes", log_q.size(), 32'd2);
    if (log_q.size() == 2) begin
      chk("wr_byte0", {16'd0, log_q[0]}, {16'd0, 7'h50, 1'b0, 8'h1A});
      chk("wr_byte1", {16'd0, log_q[1]}, {16'd0, 7'h50, 1'b0, 8'hC3});
    end
    chk("wr_ena_drop", {31'd0, ena_after_rise}, 32'd0);
    chk("wr_resp", {22'd0, resp_err, resp_timeout, resp_rdata}, {22'd0, 1'b0, 1'b0, 8'h00});
    cyc();
    chk("wr_pulse_one", {31'd0, resp_valid}, 32'd0);

    // read 0x68/0x75 -> 0x71
    log_q.delete();
    ena_after_rise = 1'b1;
    slave_rd = 8'h71;
    do_req(1'b0, 7'h68, 8'h75, 8'h00, 1'b0, lat);
    chk("rd_bytes", log_q.size(), 32'd2);
    if (log_q.size() == 2) begin
      chk("rd_byte0", {16'd0, log_q[0]}, {16'd0, 7'h68, 1'b0, 8'h75});
      chk("rd_byte1", {16'd0, log_q[1]}, {16'd0, 7'h68, 1'b1, 8'h00});
    end
    chk("rd_ena_drop", {31'd0, ena_after_rise}, 32'd0);
    chk("rd_resp", {22'd0, resp_err, resp_timeout, resp_rdata}, {22'd0, 1'b0, 1'b0, 8'h71});
    cyc();
    chk("rd_pulse_one", {31'd0, resp_valid}, 32'd0);
    repeat (3) cyc();
    chk("rd_hold", {24'd0, resp_rdata}, {24'd0, 8'h71});

    // NACK on address byte
    nack_addr = 1'b1;
    do_req(1'b1, 7'h50, 8'h01, 8'h02, 1'b0, lat);
    chk("nack_resp", {30'd0, resp_err, resp_timeout}, {30'd0, 1'b1, 1'b0});
    nack_addr = 1'b0;
    cyc();

    // back-to-back writes with req_valid held and busy lingering after STOP
    linger = 50;
    log_q.delete();
    for (int i = 0; i < 3; i++) begin
      do_req(1'b1, 7'h3C, 8'h10 + 8'(i), 8'h11 * 8'(i + 1), 1'b1, lat);
      chk("b2b_latency", lat, 32'd70);
      chk("b2b_err", {31'd0, resp_err}, 32'd0);
      chk("b2b_bytes", log_q.size(), 32'(2 * (i + 1)));
      if (log_q.size() == 2 * (i + 1))
        chk("b2b_data", {16'd0, log_q[2 * i + 1]}, {16'd0, 7'h3C, 1'b0, 8'h11 * 8'(i + 1)});
      cyc();
    end
    req_valid = 1'b0;
    linger = 3;
    repeat (3) cyc();
    chk("b2b_ready_gated", ready_viol, 32'd0);

`ifdef BTZK_I2CSEQ_TIMEOUT_EN
    // watchdog: busy held high after the first rise
    stuck = 1'b1;
    do_req(1'b1, 7'h22, 8'h33, 8'h44, 1'b0, lat);
    chk("to_latency", lat, 32'd100);
    chk("to_resp", {21'd0, resp_err, resp_timeout, m_ena, resp_rdata}, {21'd0, 1'b1, 1'b1, 1'b0, 8'h00});
    req_write = 1'b1;
    req_dev_addr = 7'h22;
    req_reg_addr = 8'h34;
    req_wdata = 8'h55;
    req_valid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (req_ready) cnt++;
    end
    chk("to_ready_withheld", cnt, 32'd0);
    stuck = 1'b0;
    do_req(1'b1, 7'h22, 8'h34, 8'h55, 1'b0, lat);
    chk("to_recover", {30'd0, resp_err, resp_timeout}, 32'd0);
    cyc();
`endif

    // asynchronous reset during SECOND, then a clean read
    log_q.delete();
    req_write = 1'b0;
    req_dev_addr = 7'h68;
    req_reg_addr = 8'h75;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 400) begin
      cyc();
      n++;
    end
    cyc();
    req_valid = 1'b0;
    n = 0;
    while (log_q.size() < 1 && n < 100) begin
      cyc();
      n++;
    end
    repeat (2) cyc();
    chk("rst_mid_ena", {31'd0, m_ena}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {11'd0, req_ready, resp_valid, resp_rdata, resp_err, resp_timeout,
                            m_ena, m_rw, m_data_wr}, 32'd0);
    chk("rst_mid_addr", {25'd0, m_addr}, 32'd0);
    #3 rst_n = 1'b1;
    cyc();
    slave_rd = 8'h5A;
    do_req(1'b0, 7'h68, 8'h75, 8'h00, 1'b0, lat);
    chk("rst_after_read", {23'd0, resp_err, resp_rdata}, {23'd0, 1'b0, 8'h5A});
    repeat (3) cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
